// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 multiply / restoring divide, signed or unsigned.
// Result is the 2*WIDTH value {HI,LO}: full product, or {remainder, quotient}.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               op_q, neg_lo, neg_hi;
  logic [WIDTH-1:0]   hi, lo, mb;

  logic               a_neg, b_neg, accept, dz;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum, sh, diff;
  logic [WIDTH-1:0]   hi_nx, lo_nx;
  logic [2*WIDTH-1:0] c_fix;

  always_comb begin
    a_neg  = sgn & A[WIDTH-1];
    b_neg  = sgn & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    accept = (state == IDLE) & start;
    dz     = op & (B == '0);
  end

  // One iteration. MUL: hi accumulates the multiplicand (mb) while the multiplier
  // shifts out of lo. DIV: hi is the partial remainder, quotient bits enter lo.
  always_comb begin
    msum  = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    sh    = {hi, lo[WIDTH-1]};
    diff  = sh - {1'b0, mb};
    hi_nx = '0;
    lo_nx = '0;
    if (op_q) begin
      // sh < 2*mb always, so diff's top bit is set exactly when sh < mb.
      hi_nx = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_nx = msum[WIDTH:1];
      lo_nx = {msum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    if (op_q)
      c_fix = {(neg_hi ? -hi : hi), (neg_lo ? -lo : lo)};
    else
      c_fix = neg_lo ? -{hi, lo} : {hi, lo};
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = dz ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mb       <= '0;
      C        <= '0;
      div_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt      <= '0;
        op_q     <= op;
        neg_lo   <= a_neg ^ b_neg;
        neg_hi   <= a_neg;
        hi       <= '0;
        lo       <= op ? a_mag : b_mag;
        mb       <= op ? b_mag : a_mag;
        div_zero <= dz;
        if (dz) C <= {A, {WIDTH{1'b1}}};
      end
      if (state == RUN) begin
        cnt <= cnt + 1'b1;
        hi  <= hi_nx;
        lo  <= lo_nx;
      end
      if (state == FIX) C <= c_fix;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32: results, latency, handshake, reset.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset, start, op, sgn;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [63:0] C;
  int          n_chk = 0;
  int          n_fail = 0;
  int          nd;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
    .A(A), .B(B), .busy(busy), .done(done), .C(C), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, optionally poke start mid-run,
  // then wait (bounded) for done and check latency and results.
  task automatic run_op(input string tag, input logic o, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expc, input logic expdz,
                        input int explat, input int poke);
    int lat;
    @(negedge clk);
    op = o; sgn = s; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = ~o; sgn = ~s;
    lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (n == poke) begin
        start = 1'b1; A = 32'd9; B = 32'd9; op = 1'b0;
      end else start = 1'b0;
      if (n == 1 && explat > 1) chk({tag, " busy"}, 64'(busy), 64'd1);
      if (done) lat = n;
    end
    start = 1'b0;
    chk({tag, " lat"}, 64'(lat), 64'(explat));
    chk({tag, " C"}, C, expc);
    chk({tag, " dz"}, 64'(div_zero), 64'(expdz));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst C", C, 64'd0);
    chk("rst dz", 64'(div_zero), 64'd0);
    reset = 1'b0;

    run_op("mul_u",   0, 0, 32'd6, 32'd3, 64'd18, 0, 34, 0);
    run_op("mul_s",   0, 1, -32'sd6, 32'd3, 64'hFFFF_FFFF_FFFF_FFEE, 0, 34, 0);
    run_op("mul_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 34, 0);
    run_op("mul_nn",  0, 1, -32'sd5, -32'sd7, 64'd35, 0, 34, 0);
    run_op("div_u",   1, 0, 32'd8, 32'd4, {32'd0, 32'd2}, 0, 34, 0);
    run_op("div_u2",  1, 0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 34, 0);
    run_op("div_s",   1, 1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 34, 0);
    run_op("div_s2",  1, 1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 0, 34, 0);
    run_op("div_z",   1, 0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1, 1, 0);
    run_op("div_min", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 34, 0);

    // start pulsed mid-run is dropped; exactly one done follows
    run_op("ign", 0, 0, 32'd6, 32'd3, 64'd18, 0, 34, 5);
    nd = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign extra done", 64'(nd), 64'd0);
    run_op("after_ign", 0, 0, 32'd7, 32'd7, 64'd49, 0, 34, 0);

    // reset mid-divide
    @(negedge clk);
    op = 1'b1; sgn = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid busy", 64'(busy), 64'd0);
    chk("rmid done", 64'(done), 64'd0);
    chk("rmid C", C, 64'd0);
    chk("rmid dz", 64'(div_zero), 64'd0);
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rmid no done", 64'(nd), 64'd0);
    run_op("mul_2x2", 0, 0, 32'd2, 32'd2, 64'd4, 0, 34, 0);

    // reset and start together: request dropped
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 1'b0; A = 32'd3; B = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start busy", 64'(busy), 64'd0);
    chk("rst_start C", C, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
